// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder: one full-adder cell reused LSB first under a ready/valid FSM

module fa (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_sum, fa_cout;

  fa u_fa (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at position 0.
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign sum_out   = out_valid ? res_q : '0;
  assign cout_out  = out_valid ? carry_q : 1'b0;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed and random scoreboard bench for serial_add_ctrl

module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic         in_ready, out_valid, cout_out, busy;
  logic [W-1:0] sum_out;

  logic         w2_valid = 1'b0, w2_ready = 1'b0, w2_cin = 1'b0;
  logic [1:0]   w2_a = '0, w2_b = '0;
  logic         w2_in_ready, w2_out_valid, w2_cout, w2_busy;
  logic [1:0]   w2_sum;

  int           checks = 0, failures = 0, n_acc = 0, n_res = 0, cyc = 0;
  logic [W:0]   sb[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .cout_out(cout_out), .busy(busy)
  );

  serial_add_ctrl #(.WIDTH(2)) dut_w2 (
    .clock(clock), .reset_n(reset_n), .in_valid(w2_valid), .in_ready(w2_in_ready),
    .a_in(w2_a), .b_in(w2_b), .cin(w2_cin), .out_valid(w2_out_valid), .out_ready(w2_ready),
    .sum_out(w2_sum), .cout_out(w2_cout), .busy(w2_busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(string tag, logic [32:0] obs, logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  // Scoreboard: push on an accepted input, pop and compare on an output handshake.
  always @(negedge clock) begin
    if (!reset_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 33'(sb.size() != 0), 33'd1);
        if (sb.size() != 0) chk("sb_result", {cout_out, sum_out}, sb.pop_front());
        n_res++;
      end
      if (in_valid && in_ready) begin
        sb.push_back({1'b0, a_in} + {1'b0, b_in} + (W+1)'(cin));
        n_acc++;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic [W:0] exp, input int hold, input bit overlap);
    int n;
    in_valid = 1'b1; a_in = a; b_in = b; cin = c;
    tick();
    in_valid = 1'b0;
    chk("in_ready_run", in_ready, 1'b0);
    n = 0;
    while (!out_valid && n < 3*W) begin
      chk("busy_run", busy, 1'b1);
      tick();
      n++;
    end
    chk("latency", n, W);
    chk("result_exp", {cout_out, sum_out}, exp);
    chk("in_ready_done", in_ready, 1'b0);
    chk("busy_done", busy, 1'b0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); a_in = W'($urandom); b_in = W'($urandom);
      tick();
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_data", {cout_out, sum_out}, exp);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1; in_valid = overlap; a_in = W'($urandom); b_in = W'($urandom);
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    chk("idle_in_ready", in_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_out_valid", out_valid, 1'b0);
    chk("idle_out_zero", {cout_out, sum_out}, '0);
  endtask

  initial begin
    int n, last, stale;
    logic [2:0] e2;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out", {cout_out, sum_out}, '0);
    tick();
    reset_n = 1'b1;

    run_add(8'h00, 8'h00, 1'b0, 9'h000, 0, 1'b0);
    run_add(8'hFF, 8'h01, 1'b0, 9'h100, 0, 1'b0);
    run_add(8'hA5, 8'h5A, 1'b1, 9'h100, 2, 1'b0);
    run_add(8'h3C, 8'h0F, 1'b1, 9'h04C, 5, 1'b1);

    // Abort mid-RUN with a reset pulse.
    in_valid = 1'b1; a_in = 8'h77; b_in = 8'h99; cin = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_out", {cout_out, sum_out}, '0);
    tick();
    reset_n = 1'b1;
    stale = 0;
    repeat (W + 4) begin
      tick();
      if (out_valid || busy) stale++;
    end
    chk("no_stale", stale, 0);
    run_add(8'h12, 8'h34, 1'b0, 9'h046, 0, 1'b0);

    // Back-to-back with in_valid/out_ready tied high.
    n_acc = 0; n_res = 0; last = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
    for (int i = 0; i < 256; i++) begin
      n = 0;
      while (busy && n < 4*W) begin tick(); n++; end
      while (!busy && n < 4*W) begin tick(); n++; end
      if (n >= 4*W) chk("accept_timeout", n, 0);
      if (i > 0) chk("period", cyc - last, W + 2);
      last = cyc;
      a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
    end
    in_valid = 1'b0;
    n = 0;
    while ((busy || out_valid) && n < 4*W) begin tick(); n++; end
    out_ready = 1'b0;
    chk("drain_idle", in_ready, 1'b1);
    chk("sb_drained", sb.size(), 0);
    chk("one_per_input", n_res, n_acc);
    chk("accepted_256", n_acc, 256);

    // WIDTH=2 exhaustive.
    for (int i = 0; i < 32; i++) begin
      w2_a = i[1:0]; w2_b = i[3:2]; w2_cin = i[4];
      e2 = {1'b0, w2_a} + {1'b0, w2_b} + {2'b00, w2_cin};
      w2_valid = 1'b1;
      tick();
      w2_valid = 1'b0;
      n = 0;
      while (!w2_out_valid && n < 8) begin tick(); n++; end
      chk("w2_latency", n, 2);
      chk("w2_result", {w2_cout, w2_sum}, e2);
      w2_ready = 1'b1;
      tick();
      w2_ready = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL expose parameter: WIDTH, 8, operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  operands a_in/b_in/cin valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have port: a_in  input  WIDTH  addend A.
REQ-007 SHALL have port: b_in  input  WIDTH  addend B.
REQ-008 SHALL have port: cin  input  1  carry-in of the add.
REQ-009 SHALL have port: out_valid  output  1  sum_out/cout_out hold a completed result.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port: sum_out  output  WIDTH  result bits [WIDTH-1:0] of A+B+cin.
REQ-012 SHALL have port: cout_out  output  1  carry out of bit WIDTH-1.
REQ-013 SHALL have port: busy  output  1  high in RUN state only.

Function
REQ-014 SHALL compute every result bit through one instance of the existing one-bit full adder fa (ports x, y, cin, sum, cout), reused serially, LSB first; no parallel adder.
REQ-015 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-016 IDLE: in_ready=1, out_valid=0, busy=0; on rising edge with in_valid=1 SHALL latch a_in, b_in into shift registers, cin into the carry register, clear bit counter to 0, go to RUN.
REQ-017 RUN: fa inputs SHALL be x=A_shift[0], y=B_shift[0], cin=carry register; each edge SHALL shift A_shift/B_shift right one bit, shift fa sum into result register MSB (result shifts right), load fa cout into carry register, increment counter.
REQ-018 RUN SHALL last exactly WIDTH cycles; on the edge where counter==WIDTH-1 SHALL go to DONE; counter width clog2(WIDTH)+1, no wrap inside RUN.
REQ-019 DONE: out_valid=1, in_ready=0; sum_out=result register, cout_out=carry register, both stable until handshake.
REQ-020 On edge with out_valid=1 and out_ready=1 SHALL return to IDLE; out_ready ignored in IDLE/RUN.
REQ-021 Latency: out_valid SHALL rise after the WIDTH-th rising edge following the accepting edge; throughput one add per WIDTH+2 cycles max.
REQ-022 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored, no operand lost or overwritten (no input buffering, no overlap).
REQ-023 Simultaneous out handshake and in_valid in DONE: SHALL complete output only; new operands accepted earliest on the following edge (in IDLE).
REQ-024 sum_out and cout_out SHALL be driven 0 whenever out_valid=0.
REQ-025 Arithmetic SHALL equal {cout_out, sum_out} = a_in + b_in + cin, modulo 2^(WIDTH+1), for all operand values.
REQ-026 Unreachable FSM encodings SHALL transition to IDLE on the next edge.

Reset
REQ-027 reset_n=0 SHALL immediately (asynchronously) force IDLE, clear shift, result, carry, counter registers; outputs in_ready=1, out_valid=0, busy=0, sum_out=0, cout_out=0.
REQ-028 Reset asserted mid-RUN or in DONE SHALL discard the operation; no out_valid pulse SHALL follow release.
REQ-029 First accepting edge SHALL be the first rising edge with reset_n=1 and in_valid=1.

Verification (WIDTH=8)
REQ-030 a=0x00,b=0x00,cin=0 accepted at edge 0 -> busy edges 1..8, out_valid after edge 8, sum_out=0x00, cout_out=0.
REQ-031 a=0xFF,b=0x01,cin=0 -> sum_out=0x00, cout_out=1; a=0xA5,b=0x5A,cin=1 -> sum_out=0x00, cout_out=1; a=0x3C,b=0x0F,cin=1 -> sum_out=0x4C, cout_out=0.
REQ-032 out_ready held 0 for 5 cycles in DONE -> out_valid=1, sum_out/cout_out unchanged, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-033 reset_n pulsed low after 4 RUN cycles -> all outputs at reset values during pulse; after release 0x12+0x34+0 -> sum_out=0x46, cout_out=0, no stale result.
REQ-034 in_valid and out_ready tied high, 256 random operand/cin triples -> every result matches a+b+cin, exactly one result per accepted input, period WIDTH+2 cycles.
REQ-035 WIDTH=2 build, exhaustive 32 combinations of a,b,cin -> all correct, out_valid after edge 2.
